// File: rtl/codec_spi_config_sequencer.sv
// codec_spi_config_sequencer
//   Walks NUM_WORDS entries of an external config ROM on each start request and
//   shifts every entry out as one SPI frame (MSB first, CPOL/CPHA from SPI_MODE),
//   capturing the MISO word of each frame.
// Ports
//   i_clock, i_reset_n      system clock, asynchronous active-low reset
//   i_enable                start request; a rising edge starts a sequence from IDLE/DONE
//   o_rom_addr, i_rom_data  ROM address out; data is expected one clock after the address changes
//   o_spi_cs_n, o_spi_clock, o_spi_mosi, i_spi_miso   SPI master pins
//   o_rx_data, o_rx_valid   captured MISO word of the last frame and its update strobe
//   o_busy, o_done          sequence running / sequence finished
//   o_state                 FSM state, for debug and checkers
// Handshake: o_rx_valid is a one-cycle strobe with no ready. The consumer must take
//   o_rx_data in that cycle; o_rx_data then holds until the next frame completes.
module codec_spi_config_sequencer #(
  parameter int SPI_DATA_WIDTH    = 32,
  parameter int SPI_CLOCK_DIVIDER = 4,
  parameter int SPI_MODE          = 0,
  parameter int NUM_WORDS         = 16,
  parameter int CS_GAP_CYCLES     = 8,
  parameter int ADDR_WIDTH        = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  output logic [ADDR_WIDTH-1:0]     o_rom_addr,
  input  logic [SPI_DATA_WIDTH-1:0] i_rom_data,
  output logic                      o_spi_cs_n,
  output logic                      o_spi_clock,
  output logic                      o_spi_mosi,
  input  logic                      i_spi_miso,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_rx_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2:0]                o_state
);

  localparam int W       = SPI_DATA_WIDTH;
  localparam logic CPOL  = 1'((SPI_MODE >> 1) & 1);
  localparam logic CPHA  = 1'(SPI_MODE & 1);
  // One counter serves SETUP, the SHIFT half-periods, HOLD and GAP.
  localparam int CNT_MAX = (SPI_CLOCK_DIVIDER > CS_GAP_CYCLES) ? SPI_CLOCK_DIVIDER : CS_GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int HALF_W  = $clog2(2 * W);

  localparam logic [CNT_W-1:0]      DIV_LAST  = CNT_W'(SPI_CLOCK_DIVIDER - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(CS_GAP_CYCLES - 1);
  localparam logic [HALF_W-1:0]     HALF_LAST = HALF_W'(2 * W - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SETUP = 3'd3,
    S_SHIFT = 3'd4,
    S_HOLD  = 3'd5,
    S_GAP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t              state;
  logic                en_q;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   half;
  logic [W-1:0]        tx_shift;
  logic [W-1:0]        rx_shift;
  logic                lead_edge;

  // SCLK toggles at the end of every half-period; the toggle that ends an
  // even-numbered half-period moves SCLK away from idle, i.e. a leading edge.
  assign lead_edge = ~half[0];
  assign o_state   = state;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      en_q        <= 1'b0;
      cnt         <= '0;
      half        <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      o_rom_addr  <= '0;
      o_spi_cs_n  <= 1'b1;
      o_spi_clock <= CPOL;
      o_spi_mosi  <= 1'b0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      en_q       <= i_enable;
      o_rx_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_enable && !en_q) begin
            state      <= S_FETCH;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_rom_addr <= '0;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          tx_shift   <= i_rom_data;
          o_spi_cs_n <= 1'b0;
          if (!CPHA) o_spi_mosi <= i_rom_data[W-1];
          cnt        <= '0;
          state      <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            half  <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt         <= '0;
            o_spi_clock <= ~o_spi_clock;
            if (lead_edge ^ CPHA) rx_shift <= {rx_shift[W-2:0], i_spi_miso};
            if (CPHA && lead_edge) begin
              o_spi_mosi <= tx_shift[W-1];
              tx_shift   <= {tx_shift[W-2:0], 1'b0};
            end
            // Mode with CPHA=0 already presented the MSB in LOAD; the final
            // trailing edge has no further bit to present.
            if (!CPHA && !lead_edge && (half != HALF_LAST)) begin
              o_spi_mosi <= tx_shift[W-2];
              tx_shift   <= {tx_shift[W-2:0], 1'b0};
            end
            if (half == HALF_LAST) state <= S_HOLD;
            else                   half  <= half + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt        <= '0;
            o_spi_cs_n <= 1'b1;
            o_rx_data  <= rx_shift;
            o_rx_valid <= 1'b1;
            state      <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (o_rom_addr == ADDR_LAST) begin
              state  <= S_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              o_rom_addr <= o_rom_addr + 1'b1;
              state      <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_spi_config_sequencer.sv
// tb_codec_spi_config_sequencer
//   Six sequencer instances share clock and reset:
//     lanes 0..3  W=8, DIV=4, GAP=8, NUM_WORDS=2, SPI_MODE=lane
//     lane 4      W=8, DIV=4, GAP=8, NUM_WORDS=1, SPI_MODE=0
//     lane 5      W=32, DIV=4, GAP=8, NUM_WORDS=2, SPI_MODE=0
//   Each lane has a synchronous ROM model and an SPI slave model that either
//   loops MOSI back to MISO or returns a reply word. All sampling and checking
//   runs on the falling clock edge from a single procedural thread.
module tb_codec_spi_config_sequencer;

  localparam int NL  = 6;
  localparam int DIV = 4;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NL-1:0] en, cs_n, sclk, mosi, miso, rx_valid, busy, done, loop, slv_bit;
  logic [7:0]    addr [NL];
  logic [2:0]    st [NL];
  logic [31:0]   rom_q [NL];
  logic [31:0]   rom [NL][2];
  logic [7:0]    rx8 [5];
  logic [31:0]   rx32;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  for (genvar g = 0; g < 4; g++) begin : g_mode
    codec_spi_config_sequencer #(
      .SPI_DATA_WIDTH(8), .SPI_CLOCK_DIVIDER(DIV), .SPI_MODE(g),
      .NUM_WORDS(2), .CS_GAP_CYCLES(GAP), .ADDR_WIDTH(8)
    ) u_dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en[g]),
      .o_rom_addr(addr[g]), .i_rom_data(rom_q[g][7:0]),
      .o_spi_cs_n(cs_n[g]), .o_spi_clock(sclk[g]), .o_spi_mosi(mosi[g]),
      .i_spi_miso(miso[g]), .o_rx_data(rx8[g]), .o_rx_valid(rx_valid[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_state(st[g])
    );
  end

  codec_spi_config_sequencer #(
    .SPI_DATA_WIDTH(8), .SPI_CLOCK_DIVIDER(DIV), .SPI_MODE(0),
    .NUM_WORDS(1), .CS_GAP_CYCLES(GAP), .ADDR_WIDTH(8)
  ) u_dut_one (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en[4]),
    .o_rom_addr(addr[4]), .i_rom_data(rom_q[4][7:0]),
    .o_spi_cs_n(cs_n[4]), .o_spi_clock(sclk[4]), .o_spi_mosi(mosi[4]),
    .i_spi_miso(miso[4]), .o_rx_data(rx8[4]), .o_rx_valid(rx_valid[4]),
    .o_busy(busy[4]), .o_done(done[4]), .o_state(st[4])
  );

  codec_spi_config_sequencer #(
    .SPI_DATA_WIDTH(32), .SPI_CLOCK_DIVIDER(DIV), .SPI_MODE(0),
    .NUM_WORDS(2), .CS_GAP_CYCLES(GAP), .ADDR_WIDTH(8)
  ) u_dut_wide (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en[5]),
    .o_rom_addr(addr[5]), .i_rom_data(rom_q[5]),
    .o_spi_cs_n(cs_n[5]), .o_spi_clock(sclk[5]), .o_spi_mosi(mosi[5]),
    .i_spi_miso(miso[5]), .o_rx_data(rx32), .o_rx_valid(rx_valid[5]),
    .o_busy(busy[5]), .o_done(done[5]), .o_state(st[5])
  );

  // Synchronous ROM: data follows the address one clock later.
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++)
      rom_q[l] <= (addr[l] < 8'd2) ? rom[l][addr[l][0]] : 32'hBAD0_BAD0;
  end

  assign miso = (loop & mosi) | (~loop & slv_bit);

  // ---------------------------------------------------------- lane setup
  function automatic int lane_w(input int l);
    return (l == 5) ? 32 : 8;
  endfunction
  function automatic int lane_mode(input int l);
    return (l < 4) ? l : 0;
  endfunction
  function automatic int lane_num(input int l);
    return (l == 4) ? 1 : 2;
  endfunction

  // --------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q [NL][$];   // expected o_rx_data words, in order
  logic [31:0] slv_q [NL][$];   // expected words seen by the slave on MOSI

  logic [NL-1:0] sclk_p, cs_p, mosi_p;
  logic [31:0]   slv_rx [NL];
  logic [31:0]   reply [NL][2];
  logic [31:0]   cur_reply [NL];
  int            bi [NL];
  int            frame_idx [NL];
  int            edges [NL];
  int            low_cnt [NL];
  int            last_low [NL];
  int            fall_cyc [NL];
  int            last_period [NL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rx_of(input int l);
    return (l == 5) ? rx32 : {24'b0, rx8[l]};
  endfunction

  // Slave models, frame timing and rx_valid scoreboard for every lane.
  task automatic monitor();
    for (int l = 0; l < NL; l++) begin
      int w;
      logic cpol, cpha, leading;
      logic [31:0] mask, r;
      w    = lane_w(l);
      cpol = 1'((lane_mode(l) >> 1) & 1);
      cpha = 1'(lane_mode(l) & 1);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);

      if (cs_p[l] && !cs_n[l]) begin
        chk($sformatf("lane%0d frame_addr", l), {24'b0, addr[l]}, frame_idx[l]);
        chk($sformatf("lane%0d sclk_idle_at_cs_fall", l), {31'b0, sclk[l]}, {31'b0, cpol});
        if (fall_cyc[l] >= 0) last_period[l] = cyc - fall_cyc[l];
        fall_cyc[l] = cyc;
        slv_rx[l]   = '0;
        edges[l]    = 0;
        low_cnt[l]  = 0;
        r = reply[l][(frame_idx[l] == 1) ? 1 : 0];
        cur_reply[l] = r;
        if (!cpha) begin
          slv_bit[l] = r[w-1];
          bi[l] = w - 2;
        end else begin
          bi[l] = w - 1;
        end
      end

      if (!cs_n[l]) begin
        low_cnt[l]++;
        if (sclk[l] != sclk_p[l]) begin
          edges[l]++;
          leading = (sclk[l] != cpol);
          if (leading == !cpha) begin
            checks++;
            if (mosi[l] !== mosi_p[l]) begin
              errors++;
              $display("FAIL lane%0d mosi_stable: got %0b expected %0b at sample edge", l, mosi[l], mosi_p[l]);
            end
            slv_rx[l] = {slv_rx[l][30:0], mosi[l]};
          end else if (bi[l] >= 0) begin
            slv_bit[l] = cur_reply[l][bi[l]];
            bi[l]--;
          end
        end
      end else begin
        chk($sformatf("lane%0d sclk_idle", l), {31'b0, sclk[l]}, {31'b0, cpol});
      end

      if (!cs_p[l] && cs_n[l]) begin
        last_low[l] = low_cnt[l];
        chk($sformatf("lane%0d sclk_edges", l), edges[l], 2 * w);
        if (slv_q[l].size() == 0) chk($sformatf("lane%0d unexpected_frame", l), 1, 0);
        else chk($sformatf("lane%0d slave_word", l), slv_rx[l] & mask, slv_q[l].pop_front());
        frame_idx[l]++;
      end

      if (rx_valid[l]) begin
        if (exp_q[l].size() == 0) chk($sformatf("lane%0d unexpected_rx_valid", l), 1, 0);
        else chk($sformatf("lane%0d rx_data", l), rx_of(l), exp_q[l].pop_front());
      end

      sclk_p[l] = sclk[l];
      cs_p[l]   = cs_n[l];
      mosi_p[l] = mosi[l];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  // -------------------------------------------------------- driver tasks
  typedef struct {
    int          lane;
    logic [31:0] rom0;
    logic [31:0] rom1;
    logic        loop;
    logic [31:0] reply0;
    logic [31:0] reply1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t tbl [8];

  task automatic prep(input vec_t v);
    int l;
    l = v.lane;
    rom[l][0] = v.rom0;
    rom[l][1] = v.rom1;
    loop[l]   = v.loop;
    reply[l][0] = v.reply0;
    reply[l][1] = v.reply1;
    frame_idx[l] = 0;
    fall_cyc[l] = -1;
    last_period[l] = 0;
    last_low[l] = 0;
    exp_q[l].push_back(v.exp0);
    slv_q[l].push_back(v.rom0);
    if (lane_num(l) == 2) begin
      exp_q[l].push_back(v.exp1);
      slv_q[l].push_back(v.rom1);
    end
  endtask

  task automatic start(input int l);
    en[l] = 1'b1;
    tick();
    en[l] = 1'b0;
    chk($sformatf("lane%0d busy_after_start", l), {31'b0, busy[l]}, 1);
    chk($sformatf("lane%0d done_cleared", l), {31'b0, done[l]}, 0);
    chk($sformatf("lane%0d addr_after_start", l), {24'b0, addr[l]}, 0);
  endtask

  task automatic wait_done(input int l);
    int n;
    n = 0;
    while (!(done[l] && !busy[l]) && n < 3000) begin
      tick();
      n++;
    end
    chk($sformatf("lane%0d done_within_budget", l), {31'b0, (n < 3000)}, 1);
  endtask

  task automatic post_checks(input int l);
    int w;
    w = lane_w(l);
    chk($sformatf("lane%0d done", l), {31'b0, done[l]}, 1);
    chk($sformatf("lane%0d busy", l), {31'b0, busy[l]}, 0);
    chk($sformatf("lane%0d final_addr", l), {24'b0, addr[l]}, lane_num(l) - 1);
    chk($sformatf("lane%0d frames", l), frame_idx[l], lane_num(l));
    chk($sformatf("lane%0d rx_left", l), exp_q[l].size(), 0);
    chk($sformatf("lane%0d slave_left", l), slv_q[l].size(), 0);
    chk($sformatf("lane%0d cs_low_width", l), last_low[l], (2 * w + 2) * DIV);
    if (lane_num(l) == 2)
      chk($sformatf("lane%0d frame_period", l), last_period[l], 2 + (2 * w + 2) * DIV + GAP);
  endtask

  task automatic run_vec(input vec_t v);
    prep(v);
    start(v.lane);
    wait_done(v.lane);
    post_checks(v.lane);
    repeat (5) tick();
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int n;
    //            lane rom0          rom1          loop reply0        reply1        exp0          exp1
    tbl[0] = '{0, 32'hA5,        32'h3C,        1'b1, 32'h0,        32'h0,        32'hA5,        32'h3C};
    tbl[1] = '{1, 32'hC3,        32'hC3,        1'b0, 32'h5A,       32'h96,       32'h5A,        32'h96};
    tbl[2] = '{2, 32'hC3,        32'hC3,        1'b1, 32'h0,        32'h0,        32'hC3,        32'hC3};
    tbl[3] = '{3, 32'hC3,        32'hC3,        1'b0, 32'h81,       32'h7E,       32'h81,        32'h7E};
    tbl[4] = '{0, 32'hFF,        32'h00,        1'b0, 32'h01,       32'h80,       32'h01,        32'h80};
    tbl[5] = '{4, 32'hC3,        32'h00,        1'b0, 32'h6D,       32'h00,       32'h6D,        32'h00};
    tbl[6] = '{3, 32'h00,        32'hFF,        1'b1, 32'h0,        32'h0,        32'h00,        32'hFF};
    tbl[7] = '{5, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'hCAFEF00D, 32'h0F0F1234, 32'hCAFEF00D, 32'h0F0F1234};

    // clock/reset
    en = '0;
    loop = '0;
    slv_bit = '0;
    for (int l = 0; l < NL; l++) begin
      rom[l][0] = '0;
      rom[l][1] = '0;
      reply[l][0] = '0;
      reply[l][1] = '0;
      cur_reply[l] = '0;
      slv_rx[l] = '0;
      bi[l] = 0;
      frame_idx[l] = 0;
      edges[l] = 0;
      low_cnt[l] = 0;
      last_low[l] = 0;
      fall_cyc[l] = -1;
      last_period[l] = 0;
      sclk_p[l] = 1'((lane_mode(l) >> 1) & 1);
      cs_p[l] = 1'b1;
      mosi_p[l] = 1'b0;
    end
    repeat (3) tick();
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d reset_cs_n", l), {31'b0, cs_n[l]}, 1);
      chk($sformatf("lane%0d reset_sclk", l), {31'b0, sclk[l]}, (lane_mode(l) >> 1) & 1);
      chk($sformatf("lane%0d reset_mosi", l), {31'b0, mosi[l]}, 0);
      chk($sformatf("lane%0d reset_addr", l), {24'b0, addr[l]}, 0);
      chk($sformatf("lane%0d reset_rx_data", l), rx_of(l), 0);
      chk($sformatf("lane%0d reset_rx_valid", l), {31'b0, rx_valid[l]}, 0);
      chk($sformatf("lane%0d reset_busy", l), {31'b0, busy[l]}, 0);
      chk($sformatf("lane%0d reset_done", l), {31'b0, done[l]}, 0);
      chk($sformatf("lane%0d reset_state", l), {29'b0, st[l]}, 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // table-driven frames: loopback, per-mode slaves, single-word and wide lanes
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // enable toggling while busy must not restart; enable held high after DONE
    prep(tbl[0]);
    start(0);
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(5, 20)) tick();
      en[0] = ~en[0];
    end
    wait_done(0);
    post_checks(0);
    repeat (150) tick();
    chk("hold_high done", {31'b0, done[0]}, 1);
    chk("hold_high busy", {31'b0, busy[0]}, 0);
    chk("hold_high frames", frame_idx[0], 2);
    en[0] = 1'b0;
    tick();
    run_vec(tbl[0]);

    // reset in the middle of the second frame's shift phase
    prep(tbl[0]);
    start(0);
    n = 0;
    while (!(st[0] == 3'd4 && addr[0] == 8'd1) && n < 500) begin
      tick();
      n++;
    end
    chk("mid_shift reached", {31'b0, (n < 500)}, 1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort cs_n", {31'b0, cs_n[0]}, 1);
    chk("abort sclk", {31'b0, sclk[0]}, 0);
    chk("abort busy", {31'b0, busy[0]}, 0);
    chk("abort rx_valid", {31'b0, rx_valid[0]}, 0);
    chk("abort addr", {24'b0, addr[0]}, 0);
    chk("abort state", {29'b0, st[0]}, 0);
    chk("abort slave_pending", slv_q[0].size(), 1);
    exp_q[0].delete();
    slv_q[0].delete();
    cs_p[0] = 1'b1;
    sclk_p[0] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
